alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
- Command/response stage between a UART receiver/transmitter pair and the ALU. Replaces the switch-and-button operand loading with serial bytes.
- Collects three received bytes in order (operand A, operand B, operation code) and holds them as registered ALU inputs.
- Returns the ALU result byte, then a flags byte, through the UART transmitter handshake.
- Sits upstream of the ALU (feeds its operands/opcode) and downstream of it (consumes result, overflow, zero).

Parameters:
- NB_DATA, 8, width of UART byte, ALU operands and ALU result.
- NB_OP, 6, width of ALU operation code; taken from the low NB_OP bits of the opcode byte. NB_OP <= NB_DATA.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- reset_button  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte; valid only in the cycle i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from UART RX: new byte on i_rx_data.
- i_tx_done  in  1  one-cycle strobe from UART TX: previous byte fully sent.
- i_alu_result  in  NB_DATA  ALU result (combinational from o_data_a/o_data_b/o_operation_code).
- i_alu_overflow  in  1  ALU overflow flag.
- i_alu_zero  in  1  ALU zero flag.
- o_data_a  out  NB_DATA  registered operand A to ALU.
- o_data_b  out  NB_DATA  registered operand B to ALU.
- o_operation_code  out  NB_OP  registered opcode to ALU.
- o_tx_data  out  NB_DATA  byte to transmit; stable from the o_tx_start cycle until i_tx_done.
- o_tx_start  out  1  one-cycle strobe to UART TX.
- o_busy  out  1  high in every state except WAIT_A/WAIT_B/WAIT_OP.
- o_rx_drop  out  1  one-cycle pulse: byte received while busy and discarded.

Behaviour:
- Reset (reset_button=1 at a clock edge, any state, including mid-transmission):
  - state=WAIT_A.
  - o_data_a, o_data_b, o_tx_data = 0; o_operation_code = 0.
  - o_tx_start, o_busy, o_rx_drop = 0.
  - Reset has priority over all strobes in the same cycle.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
- WAIT_A: on i_rx_done, o_data_a<=i_rx_data; go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b<=i_rx_data; go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation_code<=i_rx_data[NB_OP-1:0]; upper bits discarded; go to COMPUTE.
- COMPUTE: exactly one cycle so ALU inputs are registered and settled; go to SEND_RES.
- SEND_RES: o_tx_data<=i_alu_result; o_tx_start=1 for this one cycle; go to WAIT_RES.
- WAIT_RES: hold o_tx_data; on i_tx_done go to SEND_FLG.
- SEND_FLG: o_tx_data<={(NB_DATA-2)'b0, i_alu_overflow, i_alu_zero}; o_tx_start=1 for one cycle; go to WAIT_FLG.
- WAIT_FLG: on i_tx_done go to WAIT_A.
- Latency: last opcode byte strobe to first o_tx_start = 2 cycles. Result byte's i_tx_done to flags o_tx_start = 1 cycle.
- o_tx_start is never high in two consecutive cycles. Never high outside SEND_RES/SEND_FLG.
- o_data_a/o_data_b/o_operation_code hold their values across transactions until overwritten. The ALU output stays stable during both sends.
- i_rx_done in COMPUTE..WAIT_FLG: byte discarded, o_rx_drop=1 next cycle, state unchanged.
- i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
- i_rx_done and i_tx_done in the same cycle: each handled per current state independently. No interaction.
- No timeout: the FSM waits indefinitely in any WAIT_* state.

Decomposition:
- Shared package/header: state encodings (3-bit localparams), flags-byte bit positions (FLAG_ZERO=0, FLAG_OVF=1), default NB_DATA/NB_OP.
- Single module, no sub-module. The next-state/output logic is small enough to live inline. The top level instantiates uart_rx, alu_uart_interface, alu and uart_tx side by side.

Test Plan:
- Reset: hold reset_button 2 cycles -> all outputs 0, o_busy=0, state WAIT_A.
- Bytes 0x05, 0x03, 0x20, bench ALU returns 0x08, ovf=0, zero=0 -> o_data_a=0x05, o_data_b=0x03, o_operation_code=6'b100000; o_tx_start 2 cycles after third strobe with o_tx_data=0x08; after i_tx_done, o_tx_start with 0x00.
- Bytes 0x7F, 0x01, 0xE0, ALU returns 0x80, ovf=1 -> opcode=6'b100000 (upper bits dropped); result byte 0x80, flags byte 0x02.
- Extra i_rx_done (0xAA) during WAIT_RES -> o_rx_drop pulses once; operands unchanged; sequence completes normally.
- reset_button asserted in WAIT_RES -> next cycle state WAIT_A, o_tx_start stays 0, operands 0; subsequent i_tx_done ignored.
- Back-to-back transactions: second A/B/op sent right after final i_tx_done -> second result sent correctly. o_tx_start never asserted twice in a row.

Source files
------------

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART command/response stage in front of the ALU.
package alu_uart_interface_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  // Bit positions inside the flags byte returned after the result byte
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;

  typedef enum logic [2:0] {
    ST_WAIT_A   = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OP  = 3'd2,
    ST_COMPUTE  = 3'd3,
    ST_SEND_RES = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_SEND_FLG = 3'd6,
    ST_WAIT_FLG = 3'd7
  } state_t;

  // Only the three byte-collection states accept new received bytes
  function automatic logic isBusyState(input state_t s);
    return !((s == ST_WAIT_A) || (s == ST_WAIT_B) || (s == ST_WAIT_OP));
  endfunction

endpackage

// File: rtl/alu_uart_interface_if.sv
// Handshake and operand bus between UART RX/TX, the ALU and the command stage.
interface alu_uart_interface_if
  import alu_uart_interface_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
);

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_overflow;
  logic               i_alu_zero;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_operation_code;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_rx_drop;

  // Command stage side
  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_overflow, i_alu_zero,
    output o_data_a, o_data_b, o_operation_code, o_tx_data, o_tx_start, o_busy, o_rx_drop
  );

  // Surrounding UART/ALU side
  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_overflow, i_alu_zero,
    input  o_data_a, o_data_b, o_operation_code, o_tx_data, o_tx_start, o_busy, o_rx_drop
  );

endinterface

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, holds
// them as ALU inputs, then returns the result byte and a flags byte via UART TX.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic                 i_clk,
  input  logic                 reset_button,
  alu_uart_interface_if.slave  bus
);

  state_t             r_state;
  state_t             w_next_state;
  logic [NB_DATA-1:0] r_data_a;
  logic [NB_DATA-1:0] r_data_b;
  logic [NB_OP-1:0]   r_operation_code;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_rx_drop;
  logic [NB_DATA-1:0] w_flags;

  // Pack the ALU status bits into the flags byte
  always_comb begin
    w_flags            = '0;
    w_flags[FLAG_ZERO] = bus.i_alu_zero;
    w_flags[FLAG_OVF]  = bus.i_alu_overflow;
  end

  // Next-state logic; every WAIT_* state waits indefinitely for its strobe
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_WAIT_A:   if (bus.i_rx_done) w_next_state = ST_WAIT_B;
      ST_WAIT_B:   if (bus.i_rx_done) w_next_state = ST_WAIT_OP;
      ST_WAIT_OP:  if (bus.i_rx_done) w_next_state = ST_COMPUTE;
      ST_COMPUTE:  w_next_state = ST_SEND_RES;
      ST_SEND_RES: w_next_state = ST_WAIT_RES;
      ST_WAIT_RES: if (bus.i_tx_done) w_next_state = ST_SEND_FLG;
      ST_SEND_FLG: w_next_state = ST_WAIT_FLG;
      ST_WAIT_FLG: if (bus.i_tx_done) w_next_state = ST_WAIT_A;
      default:     w_next_state = ST_WAIT_A;
    endcase
  end

  // State register and datapath; the TX byte is captured one cycle before its
  // start strobe so it is already valid in the SEND_RES/SEND_FLG cycle
  always_ff @(posedge i_clk) begin
    if (reset_button) begin
      r_state          <= ST_WAIT_A;
      r_data_a         <= '0;
      r_data_b         <= '0;
      r_operation_code <= '0;
      r_tx_data        <= '0;
      r_rx_drop        <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_rx_drop <= bus.i_rx_done && isBusyState(r_state);
      case (r_state)
        ST_WAIT_A:   if (bus.i_rx_done) r_data_a <= bus.i_rx_data;
        ST_WAIT_B:   if (bus.i_rx_done) r_data_b <= bus.i_rx_data;
        ST_WAIT_OP:  if (bus.i_rx_done) r_operation_code <= bus.i_rx_data[NB_OP-1:0];
        ST_COMPUTE:  r_tx_data <= bus.i_alu_result;
        ST_WAIT_RES: if (bus.i_tx_done) r_tx_data <= w_flags;
        default:     r_tx_data <= r_tx_data;
      endcase
    end
  end

  assign bus.o_data_a         = r_data_a;
  assign bus.o_data_b         = r_data_b;
  assign bus.o_operation_code = r_operation_code;
  assign bus.o_tx_data        = r_tx_data;
  assign bus.o_tx_start       = (r_state == ST_SEND_RES) || (r_state == ST_SEND_FLG);
  assign bus.o_busy           = isBusyState(r_state);
  assign bus.o_rx_drop        = r_rx_drop;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a behavioural ALU and a byte scoreboard.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic clk;
  logic rst;
  int   assertions;
  int   failures;
  logic prevStart;
  logic [7:0] sb[$];

  alu_uart_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk        (clk),
    .reset_button (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, zero, result}
  function automatic logic [9:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (op)
      6'h20: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      6'h22: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {v, (r == 8'h00), r};
  endfunction

  logic [9:0] aluOut;
  assign aluOut             = aluModel(bus.o_data_a, bus.o_data_b, bus.o_operation_code);
  assign bus.i_alu_result   = aluOut[7:0];
  assign bus.i_alu_zero     = aluOut[8];
  assign bus.i_alu_overflow = aluOut[9];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start strobe must never be high two cycles in a row
  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) begin
      checkOutput("tx_start one-shot", {31'd0, prevStart}, 32'd0);
    end
    prevStart = (bus.o_tx_start === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'hEE;
  endtask

  task automatic pulseTxDone();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic waitTxStart(input string tag, input int expLat);
    int n;
    logic [7:0] e;
    n = 0;
    while (bus.o_tx_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " start"}, {31'd0, bus.o_tx_start}, 32'd1);
    checkOutput({tag, " latency"}, n, expLat);
    if (sb.size() == 0) begin
      checkOutput({tag, " scoreboard underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, " byte"}, {24'd0, bus.o_tx_data}, {24'd0, e});
    end
  endtask

  task automatic loadOperands(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] expRes, input logic [7:0] expFlg);
    applyStimulus(a);
    checkOutput("data_a", {24'd0, bus.o_data_a}, {24'd0, a});
    checkOutput("busy after A", {31'd0, bus.o_busy}, 32'd0);
    applyStimulus(b);
    checkOutput("data_b", {24'd0, bus.o_data_b}, {24'd0, b});
    applyStimulus(op);
    checkOutput("opcode", {26'd0, bus.o_operation_code}, {26'd0, op[5:0]});
    checkOutput("busy in compute", {31'd0, bus.o_busy}, 32'd1);
    checkOutput("no start in compute", {31'd0, bus.o_tx_start}, 32'd0);
    sb.push_back(expRes);
    sb.push_back(expFlg);
  endtask

  task automatic runTransaction(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                input logic [7:0] expRes, input logic [7:0] expFlg,
                                input bit dropInRes, input bit mergeFinal);
    loadOperands(a, b, op, expRes, expFlg);
    waitTxStart("result", 1);
    tick();
    checkOutput("start low in WAIT_RES", {31'd0, bus.o_tx_start}, 32'd0);
    checkOutput("result held", {24'd0, bus.o_tx_data}, {24'd0, expRes});
    if (dropInRes) begin
      applyStimulus(8'hAA);
      checkOutput("rx_drop pulse", {31'd0, bus.o_rx_drop}, 32'd1);
      checkOutput("data_a kept", {24'd0, bus.o_data_a}, {24'd0, a});
      checkOutput("data_b kept", {24'd0, bus.o_data_b}, {24'd0, b});
      checkOutput("opcode kept", {26'd0, bus.o_operation_code}, {26'd0, op[5:0]});
      tick();
      checkOutput("rx_drop single", {31'd0, bus.o_rx_drop}, 32'd0);
      checkOutput("result held after drop", {24'd0, bus.o_tx_data}, {24'd0, expRes});
    end
    tick();
    pulseTxDone();
    waitTxStart("flags", 0);
    tick();
    checkOutput("busy in WAIT_FLG", {31'd0, bus.o_busy}, 32'd1);
    if (mergeFinal) begin
      bus.i_rx_data = 8'h55;
      bus.i_rx_done = 1'b1;
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_rx_done = 1'b0;
      bus.i_tx_done = 1'b0;
      checkOutput("merged rx_drop", {31'd0, bus.o_rx_drop}, 32'd1);
      checkOutput("merged data_a kept", {24'd0, bus.o_data_a}, {24'd0, a});
    end else begin
      pulseTxDone();
    end
    checkOutput("idle after flags", {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    assertions    = 0;
    failures      = 0;
    prevStart     = 1'b0;
    rst           = 1'b1;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;

    $display("[TB] reset");
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset data_a", {24'd0, bus.o_data_a}, 32'd0);
    checkOutput("reset data_b", {24'd0, bus.o_data_b}, 32'd0);
    checkOutput("reset opcode", {26'd0, bus.o_operation_code}, 32'd0);
    checkOutput("reset tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    checkOutput("reset tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("reset rx_drop", {31'd0, bus.o_rx_drop}, 32'd0);
    tick();

    $display("[TB] add 0x05+0x03, merged final strobes");
    runTransaction(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b0, 1'b1);

    $display("[TB] add with overflow, opcode upper bits dropped");
    runTransaction(8'h7F, 8'h01, 8'hE0, 8'h80, 8'h02, 1'b0, 1'b0);

    $display("[TB] sub to zero with dropped byte in WAIT_RES");
    runTransaction(8'h0F, 8'h0F, 8'h22, 8'h00, 8'h01, 1'b1, 1'b0);

    $display("[TB] reset during WAIT_RES");
    loadOperands(8'h12, 8'h34, 8'h25, 8'h36, 8'h00);
    waitTxStart("pre-reset result", 1);
    tick();
    rst           = 1'b1;
    bus.i_rx_done = 1'b1;
    bus.i_tx_done = 1'b1;
    tick();
    rst           = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    if (sb.size() > 0) sb.delete();
    checkOutput("mid reset busy", {31'd0, bus.o_busy}, 32'd0);
    checkOutput("mid reset tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    checkOutput("mid reset rx_drop", {31'd0, bus.o_rx_drop}, 32'd0);
    checkOutput("mid reset data_a", {24'd0, bus.o_data_a}, 32'd0);
    checkOutput("mid reset data_b", {24'd0, bus.o_data_b}, 32'd0);
    checkOutput("mid reset opcode", {26'd0, bus.o_operation_code}, 32'd0);
    checkOutput("mid reset tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    pulseTxDone();
    checkOutput("late tx_done ignored start", {31'd0, bus.o_tx_start}, 32'd0);
    checkOutput("late tx_done ignored busy", {31'd0, bus.o_busy}, 32'd0);
    tick();
    checkOutput("still no start", {31'd0, bus.o_tx_start}, 32'd0);

    $display("[TB] back-to-back transactions");
    runTransaction(8'hF0, 8'h3C, 8'h24, 8'h30, 8'h00, 1'b0, 1'b0);
    runTransaction(8'h80, 8'h80, 8'h20, 8'h00, 8'h03, 1'b0, 1'b0);

    tick();
    checkOutput("scoreboard empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
